fifo_word_packer: RTL



---
 rtl/fifo_pack_pkg.sv | 23 ++
 rtl/fifo_word_packer.sv | 95 +++++++++
 2 files changed

// File: rtl/fifo_pack_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
package fifo_pack_pkg;

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int DEF_LANES   = 4;
  localparam int DEF_TIMEOUT = 16;
  localparam int LANE_CNT_W  = cnt_width(DEF_LANES);
  localparam int IDLE_CNT_W  = cnt_width(DEF_TIMEOUT);

  // Contiguous lane mask with the n lowest bits set.
  function automatic logic [31:0] keep_from_count(input int unsigned n);
    logic [31:0] k;
    if (n >= 32) k = '1;
    else         k = (32'd1 << n) - 32'd1;
    return k;
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Pops WIDTH-bit FIFO entries and packs LANES of them into one valid/ready word,
// flushing partial words on idle timeout or an explicit flush pulse.
import fifo_pack_pkg::*;

module fifo_word_packer #(
  parameter int WIDTH   = 8,
  parameter int LANES   = DEF_LANES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   r_clk,
  input  logic                   areset,
  input  logic                   empty,
  input  logic [WIDTH-1:0]       r_data,
  output logic                   r_enable,
  input  logic                   flush,
  output logic [WIDTH*LANES-1:0] m_data,
  output logic [LANES-1:0]       m_keep,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int LCW = cnt_width(LANES);
  localparam int ICW = cnt_width(TIMEOUT);

  state_t                     state, state_nx;
  logic [LCW-1:0]             lanes, lanes_after;
  logic [ICW-1:0]             idle_cnt;
  logic                       inflight, flush_pending;
  logic                       pop, last_land, timed_out, part_go, flush_take;
  logic [LANES-1:0][WIDTH-1:0] acc;
  logic [LANES-1:0]           keep;

  assign lanes_after = lanes + LCW'(inflight);
  assign last_land   = inflight && (lanes == LCW'(LANES - 1));
  assign timed_out   = (idle_cnt == ICW'(TIMEOUT));
  assign part_go     = (state == FILL) && !inflight && (lanes != '0) &&
                       (flush_pending || timed_out);

  // A pop in the cycle we close a partial word would land after HOLD and be lost.
  assign pop = !areset && !empty && (state != HOLD) && !flush_pending && !part_go &&
               (lanes_after < LCW'(LANES));
  assign r_enable = pop;

  // Flush only latches if something is accumulated, landing, or being popped now.
  assign flush_take = flush && (state != HOLD) && (pop || inflight || (lanes != '0));

  assign m_data  = acc;
  assign m_keep  = keep;
  assign m_valid = (state == HOLD);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pop) state_nx = FILL;
      FILL:    if (last_land || part_go) state_nx = HOLD;
      HOLD:    if (m_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge r_clk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      lanes         <= '0;
      inflight      <= 1'b0;
      idle_cnt      <= '0;
      flush_pending <= 1'b0;
      acc           <= '0;
      keep          <= '0;
    end else begin
      state    <= state_nx;
      inflight <= pop;
      if (state == HOLD) begin
        if (m_ready) begin
          lanes         <= '0;
          acc           <= '0;
          keep          <= '0;
          idle_cnt      <= '0;
          flush_pending <= 1'b0;
        end
      end else begin
        for (int i = 0; i < LANES; i++)
          if (inflight && (lanes == LCW'(i))) acc[i] <= r_data;
        lanes <= lanes_after;
        if (pop)
          idle_cnt <= '0;
        else if ((state == FILL) && !inflight && !timed_out)
          idle_cnt <= idle_cnt + ICW'(1);
        if (flush) flush_pending <= flush_take;
        if (state_nx == HOLD) keep <= LANES'(keep_from_count(32'(lanes_after)));
      end
    end
  end

endmodule
